// File: rtl/cmult_rr_sched_if.sv
// rtl/cmult_rr_sched_if.sv - requester, result and multiplier signal bundle for cmult_rr_sched
//
// Operands are packed complex integers {re[IW-1:0], im[IW-1:0]}; products
// are packed {re[ZW-1:0], im[ZW-1:0]}.
// master: the scheduler side (drives req_ready, mult_*, res_*).
// slave : the requester/multiplier environment side.
interface cmult_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int IW    = 16,
  parameter int ZW    = 2*IW+1
);
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0][2*IW-1:0]   req_a;
  logic [N_REQ-1:0][2*IW-1:0]   req_b;
  logic                         mult_en;
  logic [2*IW-1:0]              mult_a;
  logic [2*IW-1:0]              mult_b;
  logic [2*ZW-1:0]              mult_z;
  logic [N_REQ-1:0]             res_valid;
  logic [N_REQ-1:0]             res_ready;
  logic [2*ZW-1:0]              res_data;

  modport master (
    input  req_valid, req_a, req_b, mult_z, res_ready,
    output req_ready, mult_en, mult_a, mult_b, res_valid, res_data
  );

  modport slave (
    output req_valid, req_a, req_b, mult_z, res_ready,
    input  req_ready, mult_en, mult_a, mult_b, res_valid, res_data
  );
endinterface

// File: rtl/cmult_rr_sched.sv
// rtl/cmult_rr_sched.sv - round-robin scheduler sharing one pipelined complex multiplier
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (shared with the multiplier)
//   bus         cmult_rr_sched_if.master: per-requester operand valid/ready,
//               multiplier en/a/b/z, per-requester result valid/ready and
//               the shared result bus (res_data = mult_z)
// Optional (macro CMULT_RR_SCHED_STATS_EN):
//   stats_clr   synchronous clear of the counters, wins over increment
//   stall_cnt   cycles with mult_en=0, saturating
//   grant_cnt   accepted operand pairs per requester, saturating
module cmult_rr_sched #(
  parameter int N_REQ    = 4,
  parameter int PIPE_NUM = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef CMULT_RR_SCHED_STATS_EN
  input  logic                    stats_clr,
  output logic [31:0]             stall_cnt,
  output logic [N_REQ-1:0][15:0]  grant_cnt,
`endif
  cmult_rr_sched_if.master        bus
);

  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Tag pipe runs in lockstep with the multiplier; its last stage describes
  // the product currently on mult_z.
  logic [PIPE_NUM-1:0] pipe_vld;
  logic [TW-1:0]       pipe_tag [PIPE_NUM];
  logic [TW-1:0]       rr_ptr;

  logic                head_vld;
  logic [TW-1:0]       head_tag;
  logic                mult_en;
  logic                grant_any;
  logic [TW-1:0]       grant_idx;
  logic                accept;

  assign head_vld = pipe_vld[PIPE_NUM-1];
  assign head_tag = pipe_tag[PIPE_NUM-1];

  // Freeze everything only when a real result is waiting on an unready owner.
  assign mult_en     = !(head_vld && !bus.res_ready[head_tag]);
  assign bus.mult_en = mult_en;

  // Rotating priority search beginning at rr_ptr.
  always_comb begin
    int k;
    grant_any = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(rr_ptr) + i) % N_REQ;
      if (!grant_any && bus.req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = TW'(k);
      end
    end
  end

  assign accept = grant_any && mult_en;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Ungranted cycles feed 0*0 so bubbles carry a zero product.
  assign bus.mult_a = grant_any ? bus.req_a[grant_idx] : '0;
  assign bus.mult_b = grant_any ? bus.req_b[grant_idx] : '0;

  always_comb begin
    bus.res_valid = '0;
    if (head_vld) begin
      bus.res_valid[head_tag] = 1'b1;
    end
  end

  assign bus.res_data = bus.mult_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < PIPE_NUM; i++) begin
        pipe_tag[i] <= '0;
      end
    end else if (mult_en) begin
      pipe_vld    <= {pipe_vld[PIPE_NUM-2:0], accept};
      pipe_tag[0] <= grant_idx;
      for (int i = 1; i < PIPE_NUM; i++) begin
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == TW'(N_REQ-1)) ? '0 : grant_idx + TW'(1);
    end
  end

`ifdef CMULT_RR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
    end else if (!mult_en && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept && grant_idx == TW'(i) && grant_cnt[i] != 16'hFFFF) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/cmult_rr_sched.md
Name: cmult_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined complex integer multiplier (`complex_int_mult`, latency PIPE_NUM enabled cycles) between N_REQ requesters in the window-function datapath.
- Arbitrates operand pairs (a, b) with valid/ready handshakes and drives the multiplier's operands and en.
- Tracks the owner of every in-flight product in a tag pipeline and returns each result to its originating requester.
- Stalls the whole multiplier (en=0) when the result at the pipe head cannot be delivered.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PIPE_NUM, 10, multiplier latency in enabled cycles; must equal the attached multiplier's PIPE_NUM (>2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  operand pair valid, one bit per requester
- req_ready  out  N_REQ  operand pair accepted this cycle
- req_a  in  N_REQ x sample_t_int  operand a per requester
- req_b  in  N_REQ x sample_t_int  operand b per requester
- mult_en  out  1  enable to multiplier
- mult_a  out  sample_t_int  operand a to multiplier
- mult_b  out  sample_t_int  operand b to multiplier
- mult_z  in  sample_t  product from multiplier
- res_valid  out  N_REQ  result valid, one-hot or zero
- res_ready  in  N_REQ  result accepted per requester
- res_data  out  sample_t  shared result bus, equals mult_z

Behaviour:
- Reset values:
  - Tag pipe: all valid bits 0, tags 0.
  - RR pointer = 0.
  - req_ready = 0, res_valid = 0, mult_en = 1.
- Tag pipe: PIPE_NUM stages of {vld, tag[$clog2(N_REQ)-1:0]}.
  - Shifts only when mult_en=1.
  - Stage 0 loads {accept, grant_idx}.
  - The head is stage PIPE_NUM-1 and is aligned with mult_z.
- Stall rule: mult_en = !(head.vld && !res_ready[head.tag]). Combinational; no dependency on req_valid.
- Result output: res_valid[i] = head.vld && head.tag==i. A result is consumed on res_valid[i] && res_ready[i]; with mult_en=1 the pipe advances the same cycle.
- Arbitration:
  - Search req_valid starting at the RR pointer, wrapping modulo N_REQ; the first set bit is granted.
  - req_ready[g] = mult_en && req_valid[g]; at most one bit set. It is not asserted when mult_en=0.
  - mult_a/mult_b = req_a[g]/req_b[g] when granted, else 0.
  - On accept, the pointer becomes (g+1) mod N_REQ; otherwise it holds.
- Bubbles: with no accept and mult_en=1, stage 0 loads vld=0. The multiplier computes 0*0, which is discarded.
- Latency: a result appears PIPE_NUM enabled cycles after accept. Throughput is 1 per cycle with no backpressure.
- Ordering: results return in acceptance order. A requester that withholds res_ready blocks everyone (head-of-line); this is intentional.
- Stall with an empty head (head.vld=0) never occurs; mult_en=1.
- Reset mid-operation clears every in-flight tag; outstanding products are silently dropped. The multiplier shares rst_n.
- Arithmetic: none inside the block; res_data passes mult_z through unmodified.

Optional Feature:
- Macro: CMULT_RR_SCHED_STATS_EN.
- Defined:
  - Adds output stall_cnt (32 bits): counts cycles with mult_en=0, saturating at 2^32-1.
  - Adds output grant_cnt (N_REQ x 16 bits): accepts per requester, each saturating at 65535.
  - Adds input stats_clr (1 bit): synchronous clear of both counters that takes priority over increment in the same cycle.
  - All counters reset to 0 on rst_n.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Single requester: req_valid=4'b0001, a=(3+4j), b=(1-2j), res_ready all 1 -> res_valid[0] exactly 10 cycles after accept, res_data=(11-2j).
- All four requesters held valid continuously, with res_ready=1 -> grants 0,1,2,3,0,... one per cycle; res_valid one-hot in the same order starting 10 cycles later; no bubbles.
- Requesters 1 and 3 valid, pointer at 2 -> grant 3 first, then 1; pointer ends at 2.
- Backpressure: result for requester 2 at head with res_ready[2]=0 for 5 cycles -> mult_en=0, req_ready=0 and res_data stable for all 5 cycles; resumes with no loss or duplication.
- Reset asserted with 6 results in flight -> res_valid=0 immediately; after release no stale res_valid appears during the next 10 cycles.
- Stats build: 5 stall cycles plus 7 accepts by requester 1 -> stall_cnt=5, grant_cnt[1]=7; stats_clr pulse -> both counters 0 on the next cycle.
